// File: rtl/bus_pkg.sv
// Shared definitions for the rv32i data-side bus.
//   arbState_t : arbiter states (core owns bus, draining, loader owns RAM, return)
//   busId_t    : read-return source (RAM=0, UART=1)
//   owner_t    : which master a read belongs to
//   readTag_t  : one stage of the read-return tag pipe
package bus_pkg;

  typedef enum logic [1:0] {
    CORE  = 2'd0,
    DRAIN = 2'd1,
    LDR   = 2'd2,
    RET   = 2'd3
  } arbState_t;

  typedef enum logic {
    BUS_RAM  = 1'b0,
    BUS_UART = 1'b1
  } busId_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    busId_t src;
    owner_t owner;
  } readTag_t;

  localparam logic [31:0] DEF_UART_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_UART_MASK = 32'hFFFF_FFF0;

  // Loader beats are always full words.
  localparam logic [3:0]  MODE_WORD     = 4'b0010;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decode for the UART register window.
// Ports:
//   addr     in  32  bus address
//   hitU     out 1   address falls inside the UART window
//   uartAddr out 4   register offset within the window (addr[3:0])
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter logic [31:0] UART_BASE = DEF_UART_BASE,
  parameter logic [31:0] UART_MASK = DEF_UART_MASK
) (
  input  logic [31:0] addr,
  output logic        hitU,
  output logic [3:0]  uartAddr
);

  always_comb begin
    hitU     = ((addr & UART_MASK) == UART_BASE);
    uartAddr = addr[3:0];
  end

endmodule

// File: rtl/rv32i_bus_arbiter.sv
// Data-side bus arbiter between the rv32i core, the program loader, one RAM
// port and the UART register window.
// Ports:
//   clk, rstB                      clock, synchronous active-low reset
//   core_*                         core data port (addr/wdata/wrEn/rdEn/mode in,
//                                  rdata/rdataEn/clkEn out)
//   ldr_*                          loader port (req/we/addr/wdata in,
//                                  gnt/rdata/rvalid out)
//   ram_*                          RAM port (addr/wdata/wrEn/rdEn/mode out, rdata in)
//   uart_*                         UART window (sel/we/addr/wdata out, rdata in)
// Core reads return exactly 2 cycles after core_rdEn; loader reads return
// 1 cycle after the grant directly from ram_rdata.
module rv32i_bus_arbiter
  import bus_pkg::*;
#(
  parameter logic [31:0] UART_BASE = DEF_UART_BASE,
  parameter logic [31:0] UART_MASK = DEF_UART_MASK,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_wrEn,
  input  logic        core_rdEn,
  input  logic [3:0]  core_mode,
  output logic [31:0] core_rdata,
  output logic        core_rdataEn,
  output logic        core_clkEn,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic [31:0] ldr_rdata,
  output logic        ldr_rvalid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wrEn,
  output logic        ram_rdEn,
  output logic [3:0]  ram_mode,
  input  logic [31:0] ram_rdata,
  output logic        uart_sel,
  output logic        uart_we,
  output logic [3:0]  uart_addr,
  output logic [31:0] uart_wdata,
  input  logic [31:0] uart_rdata
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  arbState_t     state, stateNext;
  logic [BW-1:0] beatCnt, beatCntNext;
  logic [DW-1:0] drainCnt, drainCntNext;
  logic          holdCore, holdCoreNext;
  readTag_t      tag1, tag1Next;
  logic          coreRdPend;
  logic [31:0]   rdReg;
  logic          hitU;
  logic [3:0]    uartOff;
  logic          coreAcc;
  logic          pipeEmpty;
  logic          coreTag1;

  bus_addr_decode #(
    .UART_BASE (UART_BASE),
    .UART_MASK (UART_MASK)
  ) uDecode (
    .addr     (core_addr),
    .hitU     (hitU),
    .uartAddr (uartOff)
  );

  always_comb begin
    coreAcc   = core_rdEn | core_wrEn;
    coreTag1  = tag1.valid && (tag1.owner == OWN_CORE);
    pipeEmpty = !tag1.valid && !coreRdPend;
  end

  always_comb begin
    stateNext    = state;
    beatCntNext  = beatCnt;
    drainCntNext = drainCnt;
    holdCoreNext = holdCore;
    tag1Next     = '0;
    core_clkEn   = 1'b1;
    ldr_gnt      = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_wrEn     = 1'b0;
    ram_rdEn     = 1'b0;
    ram_mode     = '0;
    uart_sel     = 1'b0;
    uart_we      = 1'b0;
    uart_addr    = '0;
    uart_wdata   = '0;

    // Outputs stay quiet (core_clkEn high) for the whole reset cycle.
    if (rstB) begin
      unique case (state)
        CORE: begin
          holdCoreNext = 1'b0;
          if (hitU) begin
            uart_sel   = coreAcc;
            uart_we    = core_wrEn;
            uart_addr  = uartOff;
            uart_wdata = core_wdata;
            tag1Next.src = BUS_UART;
          end else begin
            ram_addr   = core_addr;
            ram_wdata  = core_wdata;
            ram_wrEn   = core_wrEn;
            ram_rdEn   = core_rdEn;
            ram_mode   = core_mode;
            tag1Next.src = BUS_RAM;
          end
          tag1Next.valid = core_rdEn;
          tag1Next.owner = OWN_CORE;
          // The core wins any same-cycle contention; the first cycle back
          // after a loader burst is reserved for the core.
          if (ldr_req && !coreAcc && !holdCore) begin
            stateNext    = DRAIN;
            drainCntNext = '0;
          end
        end

        DRAIN: begin
          core_clkEn = 1'b0;
          if (pipeEmpty || (drainCnt >= DW'(DRAIN_CYC - 1))) begin
            stateNext    = LDR;
            drainCntNext = '0;
          end else begin
            drainCntNext = drainCnt + 1'b1;
          end
        end

        LDR: begin
          core_clkEn     = 1'b0;
          ldr_gnt        = ldr_req;
          ram_addr       = ldr_addr;
          ram_wdata      = ldr_wdata;
          ram_wrEn       = ldr_req & ldr_we;
          ram_rdEn       = ldr_req & ~ldr_we;
          ram_mode       = MODE_WORD;
          tag1Next.valid = ldr_req & ~ldr_we;
          tag1Next.src   = BUS_RAM;
          tag1Next.owner = OWN_LDR;
          if (!ldr_req) begin
            stateNext = RET;
          end else begin
            beatCntNext = beatCnt + 1'b1;
            if (beatCnt >= BW'(BURST_MAX - 1)) begin
              stateNext = RET;
            end
          end
        end

        RET: begin
          // Any loader read granted last cycle returns during this cycle.
          core_clkEn   = 1'b0;
          stateNext    = CORE;
          beatCntNext  = '0;
          holdCoreNext = 1'b1;
        end

        default: stateNext = CORE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      state      <= CORE;
      beatCnt    <= '0;
      drainCnt   <= '0;
      holdCore   <= 1'b0;
      tag1       <= '0;
      coreRdPend <= 1'b0;
      rdReg      <= '0;
    end else begin
      state      <= stateNext;
      beatCnt    <= beatCntNext;
      drainCnt   <= drainCntNext;
      holdCore   <= holdCoreNext;
      tag1       <= tag1Next;
      coreRdPend <= coreTag1;
      if (coreTag1) begin
        rdReg <= (tag1.src == BUS_UART) ? uart_rdata : ram_rdata;
      end
    end
  end

  always_comb begin
    core_rdataEn = rstB & coreRdPend;
    core_rdata   = core_rdataEn ? rdReg : '0;
    ldr_rvalid   = rstB && tag1.valid && (tag1.owner == OWN_LDR);
    ldr_rdata    = ldr_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Directed bench for rv32i_bus_arbiter with a small RAM/UART slave model.
module tb_rv32i_bus_arbiter;

  logic        clk;
  logic        rstB;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_wrEn;
  logic        core_rdEn;
  logic [3:0]  core_mode;
  logic [31:0] core_rdata;
  logic        core_rdataEn;
  logic        core_clkEn;
  logic        ldr_req;
  logic        ldr_we;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;
  logic [31:0] ldr_rdata;
  logic        ldr_rvalid;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wrEn;
  logic        ram_rdEn;
  logic [3:0]  ram_mode;
  logic [31:0] ram_rdata;
  logic        uart_sel;
  logic        uart_we;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;

  int unsigned nCmp;
  int unsigned nBad;

  rv32i_bus_arbiter #(
    .UART_BASE (32'h1000_0000),
    .UART_MASK (32'hFFFF_FFF0),
    .BURST_MAX (16),
    .DRAIN_CYC (2)
  ) dut (
    .clk          (clk),
    .rstB         (rstB),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_wrEn    (core_wrEn),
    .core_rdEn    (core_rdEn),
    .core_mode    (core_mode),
    .core_rdata   (core_rdata),
    .core_rdataEn (core_rdataEn),
    .core_clkEn   (core_clkEn),
    .ldr_req      (ldr_req),
    .ldr_we       (ldr_we),
    .ldr_addr     (ldr_addr),
    .ldr_wdata    (ldr_wdata),
    .ldr_gnt      (ldr_gnt),
    .ldr_rdata    (ldr_rdata),
    .ldr_rvalid   (ldr_rvalid),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wrEn     (ram_wrEn),
    .ram_rdEn     (ram_rdEn),
    .ram_mode     (ram_mode),
    .ram_rdata    (ram_rdata),
    .uart_sel     (uart_sel),
    .uart_we      (uart_we),
    .uart_addr    (uart_addr),
    .uart_wdata   (uart_wdata),
    .uart_rdata   (uart_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: RAM with one-cycle read latency (0x40 hard-wired to
  // DEAD_BEEF), UART returning 0x5500_000<offset>.
  logic [31:0] mem [0:255];
  initial begin
    ram_rdata  = '0;
    uart_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr[9:2]] <= ram_wdata;
    if (ram_rdEn) ram_rdata <= (ram_addr == 32'h40) ? 32'hDEAD_BEEF : mem[ram_addr[9:2]];
    if (uart_sel && !uart_we) uart_rdata <= 32'h5500_0000 | {28'h0, uart_addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nBad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_addr  = '0;
    core_wdata = '0;
    core_wrEn  = 1'b0;
    core_rdEn  = 1'b0;
    core_mode  = '0;
    ldr_req    = 1'b0;
    ldr_we     = 1'b0;
    ldr_addr   = '0;
    ldr_wdata  = '0;
  endtask

  // Caller has set inputs; waits (bounded) for a grant and leaves time at
  // the sampling point of the grant cycle.
  task automatic waitGnt(input string tag);
    int unsigned n;
    n = 0;
    #1;
    while (ldr_gnt !== 1'b1 && n < 10) begin
      tick();
      #1;
      n++;
    end
    chk(tag, {31'd0, ldr_gnt}, 32'd1);
  endtask

  int unsigned grants;
  int unsigned gapCore;
  int unsigned grantsAtGap;
  int unsigned gntWithClk;
  logic        gapSeen;

  initial begin
    nCmp = 0;
    nBad = 0;
    idle();

    // Reset: strobes suppressed even with a core load pending.
    rstB      = 1'b0;
    core_addr = 32'h40;
    core_rdEn = 1'b1;
    tick();
    #1;
    chk("rst_ram_rdEn", {31'd0, ram_rdEn}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_clkEn", {31'd0, core_clkEn}, 32'd1);
    chk("rst_rdataEn", {31'd0, core_rdataEn}, 32'd0);
    tick();
    rstB = 1'b1;
    idle();
    tick();

    // Core RAM load, 2-cycle return.
    core_addr = 32'h40;
    core_rdEn = 1'b1;
    core_mode = 4'b0010;
    #1;
    chk("ld_ram_rdEn", {31'd0, ram_rdEn}, 32'd1);
    chk("ld_ram_addr", ram_addr, 32'h40);
    chk("ld_ram_mode", {28'd0, ram_mode}, 32'd2);
    chk("ld_uart_sel", {31'd0, uart_sel}, 32'd0);
    tick();
    idle();
    #1;
    chk("ld_rdataEn_n1", {31'd0, core_rdataEn}, 32'd0);
    tick();
    #1;
    chk("ld_rdataEn_n2", {31'd0, core_rdataEn}, 32'd1);
    chk("ld_rdata_n2", core_rdata, 32'hDEAD_BEEF);
    tick();
    #1;
    chk("ld_rdataEn_n3", {31'd0, core_rdataEn}, 32'd0);

    // Core UART store.
    core_addr  = 32'h1000_0004;
    core_wdata = 32'h41;
    core_wrEn  = 1'b1;
    #1;
    chk("st_uart_sel", {31'd0, uart_sel}, 32'd1);
    chk("st_uart_we", {31'd0, uart_we}, 32'd1);
    chk("st_uart_addr", {28'd0, uart_addr}, 32'd4);
    chk("st_uart_wdata", uart_wdata, 32'h41);
    chk("st_ram_wrEn", {31'd0, ram_wrEn}, 32'd0);
    chk("st_ram_rdEn", {31'd0, ram_rdEn}, 32'd0);
    tick();

    // Core UART load returns UART data.
    idle();
    core_addr = 32'h1000_0008;
    core_rdEn = 1'b1;
    #1;
    chk("uld_uart_sel", {31'd0, uart_sel}, 32'd1);
    chk("uld_uart_we", {31'd0, uart_we}, 32'd0);
    tick();
    idle();
    tick();
    #1;
    chk("uld_rdataEn", {31'd0, core_rdataEn}, 32'd1);
    chk("uld_rdata", core_rdata, 32'h5500_0008);
    tick();
    tick();

    // Loader: three writes while the core is idle.
    ldr_req   = 1'b1;
    ldr_we    = 1'b1;
    ldr_addr  = 32'h100;
    ldr_wdata = 32'hA0;
    #1;
    chk("lw_core_gnt", {31'd0, ldr_gnt}, 32'd0);
    chk("lw_core_clkEn", {31'd0, core_clkEn}, 32'd1);
    tick();
    #1;
    chk("lw_drain_gnt", {31'd0, ldr_gnt}, 32'd0);
    chk("lw_drain_clkEn", {31'd0, core_clkEn}, 32'd0);
    for (int b = 0; b < 3; b++) begin
      tick();
      ldr_addr  = 32'h100 + 32'(4 * b);
      ldr_wdata = 32'hA0 + 32'(b);
      #1;
      chk("lw_gnt", {31'd0, ldr_gnt}, 32'd1);
      chk("lw_ram_wrEn", {31'd0, ram_wrEn}, 32'd1);
      chk("lw_ram_addr", ram_addr, 32'h100 + 32'(4 * b));
      chk("lw_ram_wdata", ram_wdata, 32'hA0 + 32'(b));
      chk("lw_ram_mode", {28'd0, ram_mode}, 32'd2);
      chk("lw_clkEn", {31'd0, core_clkEn}, 32'd0);
    end
    tick();
    ldr_req = 1'b0;
    #1;
    chk("lw_end_gnt", {31'd0, ldr_gnt}, 32'd0);
    chk("lw_end_clkEn", {31'd0, core_clkEn}, 32'd0);
    tick();
    #1;
    chk("lw_ret_clkEn", {31'd0, core_clkEn}, 32'd0);
    chk("lw_ret_wrEn", {31'd0, ram_wrEn}, 32'd0);
    tick();
    #1;
    chk("lw_back_clkEn", {31'd0, core_clkEn}, 32'd1);
    tick();

    // Loader read back, then reset while a second read is in flight.
    ldr_req  = 1'b1;
    ldr_we   = 1'b0;
    ldr_addr = 32'h104;
    waitGnt("lr_gnt");
    chk("lr_ram_rdEn", {31'd0, ram_rdEn}, 32'd1);
    chk("lr_ram_addr", ram_addr, 32'h104);
    tick();
    ldr_addr = 32'h108;
    #1;
    chk("lr_rvalid", {31'd0, ldr_rvalid}, 32'd1);
    chk("lr_rdata", ldr_rdata, 32'hA1);
    chk("lr_gnt2", {31'd0, ldr_gnt}, 32'd1);
    tick();
    rstB = 1'b0;
    #1;
    chk("lrst_rvalid", {31'd0, ldr_rvalid}, 32'd0);
    chk("lrst_rdEn", {31'd0, ram_rdEn}, 32'd0);
    chk("lrst_gnt", {31'd0, ldr_gnt}, 32'd0);
    chk("lrst_clkEn", {31'd0, core_clkEn}, 32'd1);
    tick();
    rstB = 1'b1;
    idle();
    #1;
    chk("lpost_clkEn", {31'd0, core_clkEn}, 32'd1);
    chk("lpost_rvalid", {31'd0, ldr_rvalid}, 32'd0);
    chk("lpost_rdEn", {31'd0, ram_rdEn}, 32'd0);
    chk("lpost_gnt", {31'd0, ldr_gnt}, 32'd0);
    tick();

    // Core load and loader request in the same cycle: core wins.
    core_addr = 32'h100;
    core_rdEn = 1'b1;
    core_mode = 4'b0010;
    ldr_req   = 1'b1;
    ldr_we    = 1'b1;
    ldr_addr  = 32'h10C;
    ldr_wdata = 32'hB0;
    #1;
    chk("cw_ram_rdEn", {31'd0, ram_rdEn}, 32'd1);
    chk("cw_ram_addr", ram_addr, 32'h100);
    chk("cw_gnt_n0", {31'd0, ldr_gnt}, 32'd0);
    tick();
    core_addr = '0;
    core_rdEn = 1'b0;
    core_mode = '0;
    #1;
    chk("cw_gnt_n1", {31'd0, ldr_gnt}, 32'd0);
    chk("cw_rdataEn_n1", {31'd0, core_rdataEn}, 32'd0);
    tick();
    #1;
    chk("cw_rdataEn_n2", {31'd0, core_rdataEn}, 32'd1);
    chk("cw_rdata_n2", core_rdata, 32'hA0);
    chk("cw_gnt_n2", {31'd0, ldr_gnt}, 32'd0);
    chk("cw_clkEn_n2", {31'd0, core_clkEn}, 32'd0);
    tick();
    waitGnt("cw_gnt_late");
    chk("cw_wr_addr", ram_addr, 32'h10C);
    tick();
    idle();
    for (int c = 0; c < 6 && core_clkEn !== 1'b1; c++) tick();
    #1;
    chk("cw_back_clkEn", {31'd0, core_clkEn}, 32'd1);
    tick();

    // 20-beat loader burst against BURST_MAX=16.
    grants      = 0;
    gapCore     = 0;
    grantsAtGap = 0;
    gntWithClk  = 0;
    gapSeen     = 1'b0;
    for (int c = 0; c < 80; c++) begin
      ldr_req   = (grants < 20);
      ldr_we    = 1'b1;
      ldr_addr  = 32'h200 + 4 * grants;
      ldr_wdata = 32'hC0 + grants;
      #1;
      if (ldr_gnt === 1'b1) begin
        if (core_clkEn !== 1'b0) gntWithClk++;
        grants++;
      end else if (core_clkEn === 1'b1 && grants > 0 && grants < 20) begin
        if (!gapSeen) grantsAtGap = grants;
        gapSeen = 1'b1;
        gapCore++;
      end
      if (grants == 20 && core_clkEn === 1'b1) break;
      tick();
    end
    chk("bu_grants", grants, 32'd20);
    chk("bu_grants_at_gap", grantsAtGap, 32'd16);
    chk("bu_gap_core", {31'd0, gapCore >= 1}, 32'd1);
    chk("bu_gnt_clkEn", gntWithClk, 32'd0);
    idle();
    tick();

    // Back-to-back core loads of burst data, returns pipelined.
    core_addr = 32'h23C;
    core_rdEn = 1'b1;
    core_mode = 4'b0010;
    tick();
    core_addr = 32'h24C;
    tick();
    idle();
    #1;
    chk("bl_rdataEn_a", {31'd0, core_rdataEn}, 32'd1);
    chk("bl_rdata_a", core_rdata, 32'hCF);
    tick();
    #1;
    chk("bl_rdataEn_b", {31'd0, core_rdataEn}, 32'd1);
    chk("bl_rdata_b", core_rdata, 32'hD3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/rv32i_bus_arbiter.md
Name: rv32i_bus_arbiter

Overview:
- Sits between the rv32i_core data port and the shared data-side slaves: one RAM port and one UART register window.
- Decodes core accesses by address. Returns read data at the fixed 2-cycle latency the core's write-back stage expects.
- Shares the RAM port with a second master, the program loader. It pauses the core through core_clkEn while the loader owns the RAM.

Parameters:
- UART_BASE, 32'h1000_0000, base address of the UART window
- UART_MASK, 32'hFFFF_FFF0, address bits compared against UART_BASE for UART select
- BURST_MAX, 16, maximum consecutive loader beats before the core must get the bus back
- DRAIN_CYC, 2, cycles needed for an in-flight core read to complete its return

Ports:
- clk  in  1  clock
- rstB  in  1  synchronous active-low reset
- core_addr  in  32  core data address
- core_wdata  in  32  core store data
- core_wrEn  in  1  core store strobe
- core_rdEn  in  1  core load strobe
- core_mode  in  4  {byte,half,word,unsigned}
- core_rdata  out  32  load return data
- core_rdataEn  out  1  core_rdata valid
- core_clkEn  out  1  core advance enable
- ldr_req  in  1  loader request (held until granted)
- ldr_we  in  1  loader write (0 = read)
- ldr_addr  in  32  loader RAM address
- ldr_wdata  in  32  loader write data
- ldr_gnt  out  1  loader beat accepted this cycle
- ldr_rdata  out  32  loader read data
- ldr_rvalid  out  1  ldr_rdata valid
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_wrEn  out  1  RAM write strobe
- ram_rdEn  out  1  RAM read strobe
- ram_mode  out  4  RAM access mode
- ram_rdata  in  32  RAM data, valid 1 cycle after ram_rdEn
- uart_sel  out  1  UART access strobe
- uart_we  out  1  UART write
- uart_addr  out  4  UART register offset (addr[3:0])
- uart_wdata  out  32  UART write data
- uart_rdata  in  32  UART data, valid 1 cycle after uart_sel with uart_we=0

Behaviour:
- Reset: rstB is synchronous, active-low; clock clk. While rstB=0 all outputs are 0 except core_clkEn=1. State=CORE, counters=0.
- Decode: hitU = ((core_addr & UART_MASK) == UART_BASE). Loader accesses always go to RAM.
- State CORE:
  - RAM outputs mirror the core combinationally when !hitU; UART outputs mirror the core when hitU.
  - core_clkEn=1.
  - If ldr_req=1 and the core issues no access this cycle, go to DRAIN.
- State DRAIN:
  - core_clkEn=0; no new core strobes forwarded.
  - Stay DRAIN_CYC cycles (counter), or exit immediately if the read pipe is empty.
  - Then go to LDR.
- State LDR:
  - core_clkEn=0; RAM driven from the loader.
  - ldr_gnt = ldr_req, combinational.
  - Beat counter increments on each grant.
  - Leave to RET when ldr_req=0, or when the counter reaches BURST_MAX after a grant.
- State RET:
  - One cycle; core_clkEn=0, ram strobes 0.
  - Waits for a pending loader read to return, then goes to CORE and clears the beat counter.
  - CORE must then stay at least 1 cycle before re-arbitrating (fairness).
- Read return:
  - A 2-stage tag pipe records {valid, src=RAM/UART, owner=core/ldr}.
  - Stage-1 data is captured from ram_rdata or uart_rdata into a register.
  - Core: core_rdata/core_rdataEn asserted exactly 2 cycles after core_rdEn.
  - Loader: ldr_rvalid asserted 1 cycle after the granted read, with ldr_rdata=ram_rdata.
- Data path: no sign/width manipulation; ram_mode is passed through (loader beats use word mode, 4'b0010).
- Simultaneous events:
  - A core access in the same cycle as ldr_req means the core wins and the loader waits.
  - A core write and read in the same cycle is illegal and is not checked.
- Reset mid-LDR: return to CORE next cycle, drop the pending ldr_rvalid, no strobes.

Decomposition:
- Shared package bus_pkg: state enum {CORE, DRAIN, LDR, RET}, the tag struct, RAM/UART bus IDs (RAM=0, UART=1) and the default UART_BASE/UART_MASK.
- One natural sub-module, bus_addr_decode: the combinational hitU/uart_addr logic, reused by future peripherals.

Test Plan:
- Core load to 32'h0000_0040 with RAM returning 32'hDEAD_BEEF -> ram_rdEn the same cycle; core_rdataEn=1 with core_rdata=32'hDEAD_BEEF exactly 2 cycles later.
- Core store to 32'h1000_0004, data 32'h41 -> uart_sel=1, uart_we=1, uart_addr=4, uart_wdata=32'h41; no RAM strobe.
- ldr_req held while the core is idle, 3 writes -> DRAIN, then 3 ldr_gnt pulses with ram_wrEn; core_clkEn=0 throughout; CORE 1 cycle after RET.
- Core load in cycle N, ldr_req rising in N -> load completes first; loader granted only after DRAIN; core_rdataEn still at N+2.
- ldr_req held for 20 beats, BURST_MAX=16 -> 16 grants, then RET and at least 1 CORE cycle with core_clkEn=1, then the remaining 4 beats.
- rstB=0 during LDR after a loader read -> next cycle state CORE, ldr_rvalid=0, all strobes 0, core_clkEn=1.
